// File: rtl/exec_mem_if.sv
// rtl/exec_mem_if.sv - execute-stage bus: ALU operands/results, branch test, data-memory access
interface exec_mem_if;
  logic [31:0] alu_a;
  logic [31:0] alu_b;
  logic [3:0]  alu_control;
  logic [31:0] alu_result;
  logic        zero_flag;
  logic        negative_flag;
  logic        overflow_flag;
  logic [2:0]  br_op;
  logic [31:0] rs_val;
  logic        is_branch;
  logic        mem_rd;
  logic        mem_wr;
  logic [31:0] mem_wdata;
  logic [31:0] mem_rdata;

  // Datapath side that supplies operands and consumes results
  modport master (
    output alu_a, alu_b, alu_control, br_op, rs_val, mem_rd, mem_wr, mem_wdata,
    input  alu_result, zero_flag, negative_flag, overflow_flag, is_branch, mem_rdata
  );

  // Execute/memory unit
  modport slave (
    input  alu_a, alu_b, alu_control, br_op, rs_val, mem_rd, mem_wr, mem_wdata,
    output alu_result, zero_flag, negative_flag, overflow_flag, is_branch, mem_rdata
  );
endinterface

// File: rtl/exec_mem_unit.sv
// rtl/exec_mem_unit.sv - ALU, branch decision and word-addressed data memory; ALU_MUL_EN enables code E multiply
module exec_mem_unit #(
  parameter int DMEM_AW = 10,
  parameter int DATA_W  = 32
) (
  input  logic      clk,
  input  logic      reset,
  exec_mem_if.slave bus
);
  localparam int DEPTH = 1 << DMEM_AW;

  logic [DATA_W-1:0]  w_a;
  logic [DATA_W-1:0]  w_b;
  logic [DATA_W-1:0]  w_result;
  logic               w_ovf;
  logic               w_branch;
  logic [5:0]         w_popcnt;
  logic [DMEM_AW-1:0] w_addr;
  logic [DATA_W-1:0]  r_mem [0:DEPTH-1];

  assign w_a = bus.alu_a;
  assign w_b = bus.alu_b;

  // Population count of operand A for the HAM opcode
  always_comb begin
    w_popcnt = '0;
    for (int i = 0; i < DATA_W; i++) begin
      w_popcnt = w_popcnt + {5'd0, w_a[i]};
    end
  end

  // ALU operation select and signed-overflow detection
  always_comb begin
    w_result = '0;
    w_ovf    = 1'b0;
    case (bus.alu_control)
      4'h0: begin
        w_result = w_a + w_b;
        w_ovf    = (w_a[31] == w_b[31]) && (w_result[31] != w_a[31]);
      end
      4'h1: begin
        w_result = w_a - w_b;
        w_ovf    = (w_a[31] != w_b[31]) && (w_result[31] != w_a[31]);
      end
      4'h2: w_result = w_a & w_b;
      4'h3: w_result = w_a | w_b;
      4'h4: w_result = w_a ^ w_b;
      4'h5: w_result = ~(w_a | w_b);
      4'h6: w_result = ~w_a;
      4'h7: w_result = w_a << w_b[4:0];
      4'h8: w_result = w_a >> w_b[4:0];
      4'h9: w_result = $signed(w_a) >>> w_b[4:0];
      4'hA: begin
        // Implicit operand +1 is positive, so overflow only when a is positive and result flips
        w_result = w_a + 32'd1;
        w_ovf    = !w_a[31] && w_result[31];
      end
      4'hB: begin
        w_result = w_a - 32'd1;
        w_ovf    = w_a[31] && !w_result[31];
      end
      4'hC: w_result = {26'd0, w_popcnt};
      4'hD: w_result = {w_b[15:0], 16'h0000};
`ifdef ALU_MUL_EN
      4'hE: w_result = w_a * w_b;
`else
      4'hE: w_result = '0;
`endif
      4'hF: w_result = {31'd0, ($signed(w_a) < $signed(w_b))};
      default: w_result = '0;
    endcase
  end

  assign bus.alu_result    = w_result;
  assign bus.zero_flag     = (w_result == '0);
  assign bus.negative_flag = w_result[31];
  assign bus.overflow_flag = w_ovf;

  // Branch decision on rs_val; br_op[2] also selects operand A outside but is decoded here as part of the code
  always_comb begin
    w_branch = 1'b0;
    case (bus.br_op)
      3'b001: w_branch = 1'b1;
      3'b010: w_branch = bus.rs_val[31];
      3'b011: w_branch = !bus.rs_val[31] && (bus.rs_val != '0);
      3'b100: w_branch = (bus.rs_val == '0);
      3'b101: w_branch = 1'b1;
      default: w_branch = 1'b0;
    endcase
  end

  assign bus.is_branch = w_branch;

  // Upper address bits are dropped so addresses wrap around the memory depth
  assign w_addr = w_result[DMEM_AW-1:0];

  // Data memory: reset wipes every word at once, otherwise one synchronous word write per edge
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int i = 0; i < DEPTH; i++) begin
        r_mem[i] <= '0;
      end
    end else if (bus.mem_wr) begin
      r_mem[w_addr] <= bus.mem_wdata;
    end
  end

  assign bus.mem_rdata = bus.mem_rd ? r_mem[w_addr] : '0;
endmodule

// File: tb/tb_exec_mem_unit.sv
// tb/tb_exec_mem_unit.sv - scoreboard bench for exec_mem_unit
module tb_exec_mem_unit;
  logic clk;
  logic reset;
  exec_mem_if bus ();

  exec_mem_unit #(.DMEM_AW(10), .DATA_W(32)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    string       name;
    logic [31:0] exp;
  } sb_t;

  sb_t sb_q[$];
  int  errors = 0;
  int  checks = 0;

  typedef struct {
    logic [3:0]  ctrl;
    logic [31:0] a;
    logic [31:0] b;
    logic [31:0] r;
    logic        o;
  } alu_vec_t;

  typedef struct {
    logic [2:0]  op;
    logic [31:0] rs;
    logic        br;
  } br_vec_t;

  task automatic set_addr(input logic [31:0] addr);
    bus.alu_a       = addr;
    bus.alu_b       = 32'd0;
    bus.alu_control = 4'h0;
  endtask

  task automatic test_reset();
    sb_t e;
    bus.mem_rd = 1'b1;
    bus.mem_wr = 1'b0;
    set_addr(32'h0);
    sb_q.push_back('{"reset_rd_0", 32'h0});
    #1;
    e = sb_q.pop_front();
    checks++;
    if (bus.mem_rdata !== e.exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", e.name, bus.mem_rdata, e.exp);
    end
    set_addr(32'h3FF);
    sb_q.push_back('{"reset_rd_3ff", 32'h0});
    #1;
    e = sb_q.pop_front();
    checks++;
    if (bus.mem_rdata !== e.exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", e.name, bus.mem_rdata, e.exp);
    end
    @(negedge clk);
    reset = 1'b0;
    bus.mem_rd = 1'b0;
  endtask

  task automatic test_alu();
    alu_vec_t v[$];
    sb_t e;
    v.push_back('{4'h0, 32'h7FFFFFFF, 32'h1,        32'h80000000, 1'b1});
    v.push_back('{4'h1, 32'h5,        32'h5,        32'h0,        1'b0});
    v.push_back('{4'h1, 32'h80000000, 32'h1,        32'h7FFFFFFF, 1'b1});
    v.push_back('{4'h2, 32'hFF00FF00, 32'h0F0F0F0F, 32'h0F000F00, 1'b0});
    v.push_back('{4'h3, 32'hFF000000, 32'h000000FF, 32'hFF0000FF, 1'b0});
    v.push_back('{4'h4, 32'hAAAAAAAA, 32'hFFFFFFFF, 32'h55555555, 1'b0});
    v.push_back('{4'h5, 32'h0,        32'h0,        32'hFFFFFFFF, 1'b0});
    v.push_back('{4'h6, 32'h0F0F0F0F, 32'h0,        32'hF0F0F0F0, 1'b0});
    v.push_back('{4'h7, 32'h1,        32'h1F,       32'h80000000, 1'b0});
    v.push_back('{4'h8, 32'hF0000000, 32'h4,        32'h0F000000, 1'b0});
    v.push_back('{4'h9, 32'hF0000000, 32'h4,        32'hFF000000, 1'b0});
    v.push_back('{4'hA, 32'h7FFFFFFF, 32'h0,        32'h80000000, 1'b1});
    v.push_back('{4'hB, 32'h80000000, 32'h0,        32'h7FFFFFFF, 1'b1});
    v.push_back('{4'hB, 32'h0,        32'h0,        32'hFFFFFFFF, 1'b0});
    v.push_back('{4'hC, 32'h0000F00F, 32'h0,        32'h8,        1'b0});
    v.push_back('{4'hC, 32'hFFFFFFFF, 32'h0,        32'h20,       1'b0});
    v.push_back('{4'hD, 32'h0,        32'h1234,     32'h12340000, 1'b0});
    v.push_back('{4'hF, 32'hFFFFFFFF, 32'h1,        32'h1,        1'b0});
    v.push_back('{4'hF, 32'h1,        32'hFFFFFFFF, 32'h0,        1'b0});
    foreach (v[i]) begin
      bus.alu_control = v[i].ctrl;
      bus.alu_a       = v[i].a;
      bus.alu_b       = v[i].b;
      sb_q.push_back('{$sformatf("alu%0d_result", i), v[i].r});
      sb_q.push_back('{$sformatf("alu%0d_zero", i), {31'd0, (v[i].r == 32'd0)}});
      sb_q.push_back('{$sformatf("alu%0d_neg", i), {31'd0, v[i].r[31]}});
      sb_q.push_back('{$sformatf("alu%0d_ovf", i), {31'd0, v[i].o}});
      #1;
      e = sb_q.pop_front();
      checks++;
      if (bus.alu_result !== e.exp) begin
        errors++;
        $display("FAIL %s: got %h expected %h", e.name, bus.alu_result, e.exp);
      end
      e = sb_q.pop_front();
      checks++;
      if ({31'd0, bus.zero_flag} !== e.exp) begin
        errors++;
        $display("FAIL %s: got %b expected %b", e.name, bus.zero_flag, e.exp[0]);
      end
      e = sb_q.pop_front();
      checks++;
      if ({31'd0, bus.negative_flag} !== e.exp) begin
        errors++;
        $display("FAIL %s: got %b expected %b", e.name, bus.negative_flag, e.exp[0]);
      end
      e = sb_q.pop_front();
      checks++;
      if ({31'd0, bus.overflow_flag} !== e.exp) begin
        errors++;
        $display("FAIL %s: got %b expected %b", e.name, bus.overflow_flag, e.exp[0]);
      end
    end
  endtask

  task automatic test_branch();
    br_vec_t v[$];
    sb_t e;
    v.push_back('{3'b010, 32'h80000000, 1'b1});
    v.push_back('{3'b010, 32'h7FFFFFFF, 1'b0});
    v.push_back('{3'b011, 32'h0,        1'b0});
    v.push_back('{3'b011, 32'h5,        1'b1});
    v.push_back('{3'b011, 32'hFFFFFFFF, 1'b0});
    v.push_back('{3'b100, 32'h0,        1'b1});
    v.push_back('{3'b100, 32'h1,        1'b0});
    v.push_back('{3'b000, 32'h0,        1'b0});
    v.push_back('{3'b000, 32'h80000000, 1'b0});
    v.push_back('{3'b110, 32'h0,        1'b0});
    v.push_back('{3'b110, 32'h5,        1'b0});
    v.push_back('{3'b111, 32'h0,        1'b0});
    v.push_back('{3'b001, 32'h12345678, 1'b1});
    v.push_back('{3'b101, 32'h0,        1'b1});
    foreach (v[i]) begin
      bus.br_op  = v[i].op;
      bus.rs_val = v[i].rs;
      sb_q.push_back('{$sformatf("br%0d_op%0d", i, v[i].op), {31'd0, v[i].br}});
      #1;
      e = sb_q.pop_front();
      checks++;
      if ({31'd0, bus.is_branch} !== e.exp) begin
        errors++;
        $display("FAIL %s: got %b expected %b", e.name, bus.is_branch, e.exp[0]);
      end
    end
    bus.br_op = 3'b000;
  endtask

  task automatic test_mem();
    sb_t e;
    @(negedge clk);
    set_addr(32'h10);
    bus.mem_wdata = 32'hDEADBEEF;
    bus.mem_wr    = 1'b1;
    @(posedge clk);
    @(negedge clk);
    bus.mem_wr = 1'b0;
    bus.mem_rd = 1'b1;
    sb_q.push_back('{"load_10", 32'hDEADBEEF});
    #1;
    e = sb_q.pop_front();
    checks++;
    if (bus.mem_rdata !== e.exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", e.name, bus.mem_rdata, e.exp);
    end
    bus.mem_rd = 1'b0;
    sb_q.push_back('{"load_10_rd0", 32'h0});
    #1;
    e = sb_q.pop_front();
    checks++;
    if (bus.mem_rdata !== e.exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", e.name, bus.mem_rdata, e.exp);
    end
    bus.mem_rd = 1'b1;
    bus.alu_a  = 32'h400;
    bus.alu_b  = 32'h10;
    sb_q.push_back('{"alias_410", 32'hDEADBEEF});
    #1;
    e = sb_q.pop_front();
    checks++;
    if (bus.mem_rdata !== e.exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", e.name, bus.mem_rdata, e.exp);
    end
    set_addr(32'h11);
    sb_q.push_back('{"neighbour_11", 32'h0});
    #1;
    e = sb_q.pop_front();
    checks++;
    if (bus.mem_rdata !== e.exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", e.name, bus.mem_rdata, e.exp);
    end
    bus.mem_rd = 1'b0;
  endtask

  task automatic test_async_reset();
    sb_t e;
    @(negedge clk);
    set_addr(32'h20);
    bus.mem_wdata = 32'hA5A5A5A5;
    bus.mem_wr    = 1'b1;
    @(posedge clk);
    @(negedge clk);
    bus.mem_wr = 1'b0;
    bus.mem_rd = 1'b1;
    sb_q.push_back('{"pre_reset_20", 32'hA5A5A5A5});
    #1;
    e = sb_q.pop_front();
    checks++;
    if (bus.mem_rdata !== e.exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", e.name, bus.mem_rdata, e.exp);
    end
    #1;
    reset = 1'b1;
    sb_q.push_back('{"async_clear_20", 32'h0});
    #1;
    e = sb_q.pop_front();
    checks++;
    if (bus.mem_rdata !== e.exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", e.name, bus.mem_rdata, e.exp);
    end
    bus.mem_wdata = 32'h12345678;
    bus.mem_wr    = 1'b1;
    repeat (2) @(posedge clk);
    @(negedge clk);
    bus.mem_wr = 1'b0;
    reset      = 1'b0;
    sb_q.push_back('{"wr_during_reset_20", 32'h0});
    #1;
    e = sb_q.pop_front();
    checks++;
    if (bus.mem_rdata !== e.exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", e.name, bus.mem_rdata, e.exp);
    end
    set_addr(32'h10);
    sb_q.push_back('{"cleared_10", 32'h0});
    #1;
    e = sb_q.pop_front();
    checks++;
    if (bus.mem_rdata !== e.exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", e.name, bus.mem_rdata, e.exp);
    end
    bus.mem_rd = 1'b0;
  endtask

  task automatic test_rdw();
    sb_t e;
    @(negedge clk);
    set_addr(32'h3);
    bus.mem_wdata = 32'h1;
    bus.mem_wr    = 1'b1;
    @(posedge clk);
    @(negedge clk);
    bus.mem_wdata = 32'h2;
    bus.mem_rd    = 1'b1;
    sb_q.push_back('{"rdw_before_edge", 32'h1});
    sb_q.push_back('{"rdw_after_edge", 32'h2});
    #1;
    e = sb_q.pop_front();
    checks++;
    if (bus.mem_rdata !== e.exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", e.name, bus.mem_rdata, e.exp);
    end
    @(posedge clk);
    #1;
    e = sb_q.pop_front();
    checks++;
    if (bus.mem_rdata !== e.exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", e.name, bus.mem_rdata, e.exp);
    end
    bus.mem_wr = 1'b0;
    bus.mem_rd = 1'b0;
  endtask

  task automatic test_mul();
    sb_t e;
    logic [31:0] exp_r;
`ifdef ALU_MUL_EN
    exp_r = 32'hF;
`else
    exp_r = 32'h0;
`endif
    bus.alu_control = 4'hE;
    bus.alu_a       = 32'h3;
    bus.alu_b       = 32'h5;
    sb_q.push_back('{"mul_result", exp_r});
    sb_q.push_back('{"mul_zero", {31'd0, (exp_r == 32'd0)}});
    sb_q.push_back('{"mul_ovf", 32'h0});
    #1;
    e = sb_q.pop_front();
    checks++;
    if (bus.alu_result !== e.exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", e.name, bus.alu_result, e.exp);
    end
    e = sb_q.pop_front();
    checks++;
    if ({31'd0, bus.zero_flag} !== e.exp) begin
      errors++;
      $display("FAIL %s: got %b expected %b", e.name, bus.zero_flag, e.exp[0]);
    end
    e = sb_q.pop_front();
    checks++;
    if ({31'd0, bus.overflow_flag} !== e.exp) begin
      errors++;
      $display("FAIL %s: got %b expected %b", e.name, bus.overflow_flag, e.exp[0]);
    end
  endtask

  initial begin
    reset           = 1'b1;
    bus.alu_a       = 32'h0;
    bus.alu_b       = 32'h0;
    bus.alu_control = 4'h0;
    bus.br_op       = 3'b000;
    bus.rs_val      = 32'h0;
    bus.mem_rd      = 1'b0;
    bus.mem_wr      = 1'b0;
    bus.mem_wdata   = 32'h0;
    #2;
    test_reset();
    test_alu();
    test_branch();
    test_mem();
    test_async_reset();
    test_rdw();
    test_mul();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
